// File: rtl/forward_pkg.sv
// Shared pipeline constants for the 5-stage MIPS datapath: widths, the zero
// register, and bit positions of the EX/MEM and MEM/WB pipeline registers.
package forward_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // EXMEMReg field positions
  localparam int EXMEM_REGWRITE   = 74;
  localparam int EXMEM_MEMWRITE   = 73;
  localparam int EXMEM_MEMTOREG   = 72;
  localparam int EXMEM_MEMREAD    = 71;
  localparam int EXMEM_WREG_HI    = 68;
  localparam int EXMEM_WREG_LO    = 64;
  localparam int EXMEM_WDATA_HI   = 63;
  localparam int EXMEM_WDATA_LO   = 32;
  localparam int EXMEM_ALU_HI     = 31;
  localparam int EXMEM_ALU_LO     = 0;

  // MEMWBReg field positions
  localparam int MEMWB_MEMTOREG   = 70;
  localparam int MEMWB_ADDR_HI    = 69;
  localparam int MEMWB_ADDR_LO    = 38;
  localparam int MEMWB_REGWRITE   = 37;
  localparam int MEMWB_WREG_HI    = 36;
  localparam int MEMWB_WREG_LO    = 32;
  localparam int MEMWB_RDDATA_HI  = 31;
  localparam int MEMWB_RDDATA_LO  = 0;

endpackage

// File: rtl/forward_mux2.sv
// Generic DATA_W-wide 2:1 select, shared by the pipeline's datapath muxes.
module forward_mux2 #(
  parameter int DATA_W = forward_pkg::DATA_W
) (
  input  logic              i_sel,
  input  logic [DATA_W-1:0] i_a0,
  input  logic [DATA_W-1:0] i_a1,
  output logic [DATA_W-1:0] o_y
);

  assign o_y = i_sel ? i_a1 : i_a0;

endmodule

// File: rtl/forward.sv
// Memory-stage store-data forwarding: a load in MEM/WB feeds its read data to
// a dependent store in MEM. Also keeps a delayed hit flag and a saturating count.
module forward #(
  parameter int DATA_W = forward_pkg::DATA_W,
  parameter int REG_W  = forward_pkg::REG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  RegLw,
  input  logic [REG_W-1:0]  RegSw,
  input  logic              WriteEnable,
  input  logic              MemToRegWrite,
  input  logic              StoreValid,
  input  logic [DATA_W-1:0] LwData,
  input  logic [DATA_W-1:0] SwData,
  output logic              forwardF,
  output logic [DATA_W-1:0] StoreData,
  output logic              forwardF_q,
  output logic [CNT_W-1:0]  ForwardCount
);

  import forward_pkg::*;

  logic             w_hit;
  logic             r_hit_p0;
  logic [CNT_W-1:0] r_cnt_p0;

  // Register 0 is hardwired to zero, so a load "to $0" must never forward.
  assign w_hit = !rst && WriteEnable && MemToRegWrite && StoreValid &&
                 (RegLw != REG_W'(REG_ZERO)) && (RegLw == RegSw);

  forward_mux2 #(.DATA_W(DATA_W)) u_mux (
    .i_sel (w_hit),
    .i_a0  (SwData),
    .i_a1  (LwData),
    .o_y   (StoreData)
  );

  // stage p0: delayed hit flag and saturating event counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_p0 <= 1'b0;
      r_cnt_p0 <= '0;
    end else begin
      r_hit_p0 <= w_hit;
      if (w_hit && (r_cnt_p0 != {CNT_W{1'b1}}))
        r_cnt_p0 <= r_cnt_p0 + 1'b1;
    end
  end

  assign forwardF     = w_hit;
  assign forwardF_q   = r_hit_p0;
  assign ForwardCount = r_cnt_p0;

endmodule

// File: tb/tb_forward.sv
// Scoreboard bench for forward: a 16-bit-counter instance and a 3-bit one
// (for saturation) share the same stimulus.
module tb_forward;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RegLw, RegSw;
  logic        we, mtr, sv;
  logic [31:0] ld, sd;

  logic        f16, fq16, f3, fq3;
  logic [31:0] sdo16, sdo3;
  logic [15:0] cnt16;
  logic [2:0]  cnt3;

  always #5 clk = ~clk;

  forward #(.DATA_W(32), .REG_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .RegLw(RegLw), .RegSw(RegSw),
    .WriteEnable(we), .MemToRegWrite(mtr), .StoreValid(sv),
    .LwData(ld), .SwData(sd),
    .forwardF(f16), .StoreData(sdo16), .forwardF_q(fq16), .ForwardCount(cnt16)
  );

  forward #(.DATA_W(32), .REG_W(5), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .RegLw(RegLw), .RegSw(RegSw),
    .WriteEnable(we), .MemToRegWrite(mtr), .StoreValid(sv),
    .LwData(ld), .SwData(sd),
    .forwardF(f3), .StoreData(sdo3), .forwardF_q(fq3), .ForwardCount(cnt3)
  );

  typedef struct packed {
    logic        f;
    logic [31:0] sd;
  } comb_t;

  typedef struct packed {
    logic        fq;
    logic [15:0] c16;
    logic [2:0]  c3;
  } reg_t;

  comb_t q_comb[$];
  reg_t  q_reg[$];

  int total = 0;
  int bad   = 0;

  logic m_fq  = 1'b0;
  int   m_c16 = 0;
  int   m_c3  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] l, input logic [4:0] s,
                      input logic w, input logic m, input logic v,
                      input logic [31:0] a, input logic [31:0] b);
    comb_t ec;
    reg_t  er;
    logic  h;
    @(negedge clk);
    rst = r; RegLw = l; RegSw = s; we = w; mtr = m; sv = v; ld = a; sd = b;
    h = !r && w && m && v && (l != 5'd0) && (l == s);
    ec.f  = h;
    ec.sd = h ? a : b;
    q_comb.push_back(ec);
    #1;
    ec = q_comb.pop_front();
    chk("fwd",      32'(f16),   32'(ec.f));
    chk("fwd_sat",  32'(f3),    32'(ec.f));
    chk("sdata",    sdo16,      ec.sd);
    chk("sdata_sat", sdo3,      ec.sd);
    @(posedge clk);
    if (r) begin
      m_fq = 1'b0; m_c16 = 0; m_c3 = 0;
    end else begin
      m_fq = h;
      if (h && m_c16 < 65535) m_c16++;
      if (h && m_c3 < 7)      m_c3++;
    end
    er.fq  = m_fq;
    er.c16 = 16'(m_c16);
    er.c3  = 3'(m_c3);
    q_reg.push_back(er);
    #1;
    er = q_reg.pop_front();
    chk("fwd_q",     32'(fq16),  32'(er.fq));
    chk("fwd_q_sat", 32'(fq3),   32'(er.fq));
    chk("cnt",       32'(cnt16), 32'(er.c16));
    chk("cnt_sat",   32'(cnt3),  32'(er.c3));
  endtask

  localparam logic [31:0] LW = 32'h01010011;
  localparam logic [31:0] SW = 32'h01010101;

  initial begin
    rst = 1'b1; RegLw = '0; RegSw = '0; we = 1'b0; mtr = 1'b0; sv = 1'b0;
    ld = '0; sd = '0;

    // reset state, with hit inputs present to confirm gating
    step(1, 5'd27, 5'd27, 1, 1, 1, LW, SW);
    step(1, 5'd0,  5'd0,  0, 0, 0, LW, SW);

    // basic hit, register mismatch, qualifier sweep, register zero
    step(0, 5'd27, 5'd27, 1, 1, 1, LW, SW);
    step(0, 5'd27, 5'd31, 1, 1, 1, LW, SW);
    step(0, 5'd27, 5'd27, 0, 1, 1, LW, SW);
    step(0, 5'd27, 5'd27, 1, 0, 1, LW, SW);
    step(0, 5'd27, 5'd27, 1, 1, 0, LW, SW);
    step(0, 5'd0,  5'd0,  1, 1, 1, LW, SW);

    // reset mid-run: three hits, reset with hit inputs held, then resume
    step(1, 5'd0,  5'd0,  0, 0, 0, LW, SW);
    for (int i = 0; i < 3; i++) step(0, 5'd27, 5'd27, 1, 1, 1, LW, SW);
    chk("cnt_three", 32'(cnt16), 32'd3);
    step(1, 5'd27, 5'd27, 1, 1, 1, LW, SW);
    step(0, 5'd27, 5'd27, 1, 1, 1, LW, SW);

    // saturation of the 3-bit counter
    for (int i = 0; i < 10; i++) step(0, 5'd5, 5'd5, 1, 1, 1, 32'hDEADBEEF, 32'h12345678);
    chk("sat_hold", 32'(cnt3), 32'd7);
    step(0, 5'd5, 5'd6, 1, 1, 1, 32'hDEADBEEF, 32'h12345678);

    // random traffic over a small register set to provoke frequent matches
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 7) != 0), $urandom, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
